// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the synchronous-read
// instruction memory address and pairs the returned word with its PC.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_i             decode cannot accept; hold the current IF output
//   redirect_i          EX taken branch/jump; refetch from redirect_pc_i
//   redirect_pc_i       redirect target byte address
//   imem_addr_o         word address to instruction memory (combinational)
//   imem_instr_i        memory read data, valid one cycle after the address
//   if_instr_o          instruction to decode (NOP when not valid)
//   if_pc_o             byte PC of if_instr_o
//   if_pc_plus4_o       if_pc_o + 4 (link value)
//   if_valid_o          if_instr_o is a real fetched instruction
//   misalign_o          sticky: some redirect target had pc[1:0] != 0
//   fetch_count_o       fetches issued since reset
module fetch_stage #(
  parameter int                ADDR_W    = 4,
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [XLEN-1:0]   imem_instr_i,
  output logic [XLEN-1:0]   if_instr_o,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [XLEN-1:0]   if_pc_plus4_o,
  output logic              if_valid_o,
  output logic              misalign_o,
  output logic [31:0]       fetch_count_o
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] f_pc_q, f_pc_d;
  logic            f_valid_q, f_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] tgt;

  assign tgt = {redirect_pc_i[XLEN-1:2], 2'b00};

  // During a stall the displayed word is re-read so the memory's
  // output register keeps presenting the same instruction.
  always_comb begin
    imem_addr_o = pc_q[ADDR_W+1:2];
    if (redirect_i) begin
      imem_addr_o = redirect_pc_i[ADDR_W+1:2];
    end else if (stall_i) begin
      imem_addr_o = f_pc_q[ADDR_W+1:2];
    end
  end

  always_comb begin
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    f_valid_d  = f_valid_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    if (redirect_i) begin
      f_pc_d    = tgt;
      pc_d      = tgt + FOUR;
      f_valid_d = 1'b1;
      cnt_d     = cnt_q + 32'd1;
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!stall_i) begin
      f_pc_d    = pc_q;
      pc_d      = pc_q + FOUR;
      f_valid_d = 1'b1;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      f_pc_q     <= RESET_PC;
      f_valid_q  <= 1'b0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      f_valid_q  <= f_valid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign if_instr_o    = f_valid_q ? imem_instr_i : NOP_INSTR;
  assign if_pc_o       = f_pc_q;
  assign if_pc_plus4_o = f_pc_q + FOUR;
  assign if_valid_o    = f_valid_q;
  assign misalign_o    = misalign_q;
  assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic
// checked against a behavioural PC/fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic [3:0]  addr;
  logic [31:0] mem_q;
  logic [31:0] instr, pc, pc4, cnt;
  logic        valid, mis;

  int errs = 0;
  int checks = 0;

  // model: next fetch PC, displayed PC, valid, count, sticky misalign
  logic [31:0] m_pc, m_fpc, m_cnt;
  logic        m_v, m_mis;

  always #5 clk = ~clk;

  // instruction memory: word i holds A000_0000 + i, registered read
  always @(posedge clk) mem_q <= 32'hA000_0000 + 32'(addr);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .imem_addr_o   (addr),
    .imem_instr_i  (mem_q),
    .if_instr_o    (instr),
    .if_pc_o       (pc),
    .if_pc_plus4_o (pc4),
    .if_valid_o    (valid),
    .misalign_o    (mis),
    .fetch_count_o (cnt)
  );

  function automatic logic [31:0] e_instr();
    return m_v ? 32'hA000_0000 + 32'(m_fpc[5:2]) : 32'h13;
  endfunction

  function automatic logic [3:0] e_addr();
    if (redir) return rpc[5:2];
    if (stall) return m_fpc[5:2];
    return m_pc[5:2];
  endfunction

  task automatic model_reset();
    m_pc = 0; m_fpc = 0; m_cnt = 0; m_v = 0; m_mis = 0;
  endtask

  // one clock: the model applies the fetch rules to the inputs in force
  task automatic step();
    @(posedge clk);
    if (redir) begin
      m_fpc = rpc & ~32'd3;
      m_pc  = m_fpc + 4;
      m_v   = 1;
      m_cnt = m_cnt + 1;
      if (rpc % 4 != 0) m_mis = 1;
    end else if (!stall) begin
      m_fpc = m_pc;
      m_pc  = m_pc + 4;
      m_v   = 1;
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    stall = 0; redir = 0; rpc = 0;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    stall = 0; redir = 0; rpc = 0;
    #3 rst = 1;
    model_reset();
    #1;
    checks++; if (valid !== 1'b0) begin errs++;
      $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (instr !== 32'h13) begin errs++;
      $display("FAIL rst_instr: got %h want 00000013", instr); end
    checks++; if (pc !== 0 || pc4 !== 4) begin errs++;
      $display("FAIL rst_pc: got %h/%h want 0/4", pc, pc4); end
    checks++; if (cnt !== 0 || mis !== 1'b0) begin errs++;
      $display("FAIL rst_cnt_mis: got %0d/%b want 0/0", cnt, mis); end
    checks++; if (addr !== 4'd0) begin errs++;
      $display("FAIL rst_addr: got %0d want 0", addr); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    checks++; if (valid !== 1'b0) begin errs++;
      $display("FAIL seq_first_valid: got %b want 0", valid); end
    for (int i = 0; i < 20; i++) begin
      checks++; if (addr !== 4'(i)) begin errs++;
        $display("FAIL seq_addr[%0d]: got %0d want %0d", i, addr, i % 16); end
      step();
      checks++; if (pc !== 32'(4*i) || pc4 !== 32'(4*i+4)) begin errs++;
        $display("FAIL seq_pc[%0d]: got %h/%h want %h", i, pc, pc4, 4*i); end
      checks++;
      if (instr !== 32'hA000_0000 + 32'(i % 16) || valid !== 1'b1) begin
        errs++;
        $display("FAIL seq_instr[%0d]: got %h v%b want %h v1",
                 i, instr, valid, 32'hA000_0000 + 32'(i % 16));
      end
      checks++; if (cnt !== 32'(i+1)) begin errs++;
        $display("FAIL seq_cnt[%0d]: got %0d want %0d", i, cnt, i+1); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (3) step();
    checks++; if (pc !== 32'h8) begin errs++;
      $display("FAIL stall_pre_pc: got %h want 8", pc); end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (addr !== 4'd2) begin errs++;
        $display("FAIL stall_addr[%0d]: got %0d want 2", i, addr); end
      step();
      checks++;
      if (pc !== 32'h8 || instr !== 32'hA000_0002 || cnt !== 32'd3) begin
        errs++;
        $display("FAIL stall_hold[%0d]: got %h %h %0d want 8 A0000002 3",
                 i, pc, instr, cnt);
      end
    end
    stall = 0;
    step();
    checks++;
    if (pc !== 32'hC || instr !== 32'hA000_0003 || cnt !== 32'd4) begin
      errs++;
      $display("FAIL stall_release: got %h %h %0d want c A0000003 4",
               pc, instr, cnt);
    end
  endtask

  task automatic test_redirect();
    stall = 1; redir = 1; rpc = 32'h14;
    #1;
    checks++; if (addr !== 4'd5) begin errs++;
      $display("FAIL redir_addr: got %0d want 5", addr); end
    step();
    stall = 0; redir = 0;
    checks++;
    if (pc !== 32'h14 || pc4 !== 32'h18 || instr !== 32'hA000_0005) begin
      errs++;
      $display("FAIL redir_tgt: got %h %h %h want 14 18 A0000005",
               pc, pc4, instr);
    end
    checks++; if (mis !== 1'b0 || cnt !== 32'd5) begin errs++;
      $display("FAIL redir_mis_cnt: got %b %0d want 0 5", mis, cnt); end
    step();
    checks++; if (pc !== 32'h18 || instr !== 32'hA000_0006) begin errs++;
      $display("FAIL redir_next: got %h %h want 18 A0000006", pc, instr); end
  endtask

  task automatic test_misalign();
    redir = 1; rpc = 32'h1E;
    step();
    redir = 0;
    checks++;
    if (pc !== 32'h1C || instr !== 32'hA000_0007 || mis !== 1'b1) begin
      errs++;
      $display("FAIL mis_tgt: got %h %h %b want 1c A0000007 1",
               pc, instr, mis);
    end
    for (int i = 0; i < 4; i++) begin
      stall = (i == 1);
      step();
      checks++; if (mis !== 1'b1) begin errs++;
        $display("FAIL mis_sticky[%0d]: got %b want 1", i, mis); end
    end
    stall = 0;
  endtask

  task automatic test_stall_invalid();
    do_reset();
    stall = 1;
    repeat (2) step();
    checks++;
    if (valid !== 1'b0 || instr !== 32'h13 || cnt !== 0) begin
      errs++;
      $display("FAIL stall_inv: got v%b %h %0d want v0 00000013 0",
               valid, instr, cnt);
    end
    stall = 0;
    step();
    checks++; if (valid !== 1'b1 || pc !== 0 || instr !== 32'hA000_0000) begin
      errs++;
      $display("FAIL stall_inv_rel: got v%b %h %h want v1 0 A0000000",
               valid, pc, instr);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      redir = ($urandom % 8) == 0;
      rpc   = ($urandom % 16 == 0) ? $urandom : ($urandom % 128);
      #1;
      checks++; if (addr !== e_addr()) begin errs++; bad++;
        if (bad < 10) $display("FAIL rnd_addr[%0d]: got %0d want %0d",
                               i, addr, e_addr()); end
      step();
      checks++;
      if (pc !== m_fpc || pc4 !== m_fpc + 4 || valid !== m_v ||
          instr !== e_instr() || cnt !== m_cnt || mis !== m_mis) begin
        errs++; bad++;
        if (bad < 10)
          $display("FAIL rnd_out[%0d]: got %h %h %b %h %0d %b want %h %h %b %h %0d %b",
                   i, pc, pc4, valid, instr, cnt, mis,
                   m_fpc, m_fpc + 4, m_v, e_instr(), m_cnt, m_mis);
      end
    end
    stall = 0; redir = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    redir = 1; rpc = 32'h21;
    step();
    redir = 0;
    repeat (3) step();
    stall = 1;
    step();
    #3 rst = 1;
    #1;
    checks++;
    if (valid !== 1'b0 || instr !== 32'h13 || cnt !== 0 || mis !== 1'b0) begin
      errs++;
      $display("FAIL arst_now: got v%b %h %0d m%b want v0 00000013 0 m0",
               valid, instr, cnt, mis);
    end
    checks++; if (pc !== 0 || addr !== 4'd0) begin errs++;
      $display("FAIL arst_pc: got %h %0d want 0 0", pc, addr); end
    model_reset();
    @(negedge clk);
    rst = 0; stall = 0;
    step();
    checks++;
    if (pc !== 0 || instr !== 32'hA000_0000 || valid !== 1'b1 || cnt !== 1)
    begin
      errs++;
      $display("FAIL arst_restart: got %h %h v%b %0d want 0 A0000000 v1 1",
               pc, instr, valid, cnt);
    end
  endtask

  initial begin
    rst = 1; stall = 0; redir = 0; rpc = 0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misalign();
    test_stall_invalid();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the RV32I pipeline; sits directly upstream of instruction_memory.
- Owns the PC, generates the word address for the synchronous-read instruction memory, and pairs the returned instruction with its PC.
- The memory's output register serves as the IF/ID boundary.
- Handles decode stall, EX-stage redirect (branch/jump), and misaligned redirect detection.

Parameters:
ADDR_W, 4, instruction-memory word-address width (memory holds 2^ADDR_W words)
XLEN, 32, PC/instruction width
RESET_PC, 32'h0000_0000, PC fetched first after reset (must be 4-byte aligned)
NOP_INSTR, 32'h0000_0013, instruction presented when no valid fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
stall_i  in  1  decode cannot accept; hold current IF output
redirect_i  in  1  EX resolved taken branch/jump; refetch from redirect_pc_i
redirect_pc_i  in  XLEN  redirect target byte address
imem_addr_o  out  ADDR_W  word address to instruction_memory.addr (combinational)
imem_instr_i  in  XLEN  instruction_memory.instr, valid one cycle after the address
if_instr_o  out  XLEN  instruction to decode
if_pc_o  out  XLEN  byte PC of if_instr_o
if_pc_plus4_o  out  XLEN  if_pc_o + 4 (link value)
if_valid_o  out  1  if_instr_o is a real fetched instruction
misalign_o  out  1  sticky: a redirect target had pc[1:0] != 0
fetch_count_o  out  32  number of fetches issued since reset

Behaviour:
- State: pc_r (next PC to issue), f_pc_r (PC whose data is on imem_instr_i this cycle), f_valid_r, misalign_r, fetch_count_r.
- Reset (async, immediate on rst=1):
  - pc_r=RESET_PC, f_pc_r=RESET_PC, f_valid_r=0, misalign_r=0, fetch_count_r=0.
  - Outputs: if_valid_o=0, if_instr_o=NOP_INSTR, if_pc_o=RESET_PC, if_pc_plus4_o=RESET_PC+4, misalign_o=0, fetch_count_o=0, imem_addr_o=RESET_PC[ADDR_W+1:2].
- Issue address (combinational), priority order:
  1. redirect_i: imem_addr_o = {redirect_pc_i[..:2]}[ADDR_W-1:0].
  2. stall_i: imem_addr_o = f_pc_r[ADDR_W+1:2]. Re-reads the displayed word so memory output holds.
  3. Otherwise: imem_addr_o = pc_r[ADDR_W+1:2].
- Update on clk edge (rst=0):
  - Redirect, taking precedence over stall: t = {redirect_pc_i[XLEN-1:2],2'b00}. Then f_pc_r<=t, pc_r<=t+4, f_valid_r<=1, fetch_count_r+=1. Also misalign_r<=1 if redirect_pc_i[1:0]!=0.
  - Stall, no redirect: pc_r, f_pc_r, f_valid_r, fetch_count_r all hold.
  - Normal: f_pc_r<=pc_r, pc_r<=pc_r+4, f_valid_r<=1, fetch_count_r+=1.
- Outputs:
  - if_instr_o = f_valid_r ? imem_instr_i : NOP_INSTR.
  - if_pc_o = f_pc_r; if_pc_plus4_o = f_pc_r+4; if_valid_o = f_valid_r.
- Latency: address issued in cycle n → instruction/PC on IF outputs in cycle n+1. First valid instruction appears one cycle after reset deassert.
- Redirect penalty: the instruction on IF outputs during the redirect cycle is wrong-path; decode/EX squash it. The target appears next cycle.
- PC arithmetic is modulo 2^XLEN. Memory indexing uses only pc[ADDR_W+1:2], so fetch wraps to word 0 past the last word while the PC keeps counting.
- fetch_count_r wraps at 2^32.
- Stall while f_valid_r=0 holds the invalid state; no fetch is issued.
- Reset mid-stall or mid-redirect discards everything; fetch restarts from RESET_PC.

Test Plan:
- Memory word i = 32'hA000_0000+i, RESET_PC=0. Release reset, no stall → imem_addr_o 0,1,2,… per cycle; if_pc_o 0,4,8,…; if_instr_o A0000000,A0000001,…, one cycle later; if_valid_o=0 only in the first cycle; fetch_count_o increments each cycle.
- stall_i high 3 cycles while if_pc_o=8 → if_pc_o=8, if_instr_o=A0000002, fetch_count_o constant for all 3 cycles; after release the next cycle shows pc 12, A0000003.
- redirect_i with redirect_pc_i=0x14 (stall also high) → next cycle if_pc_o=0x14, if_instr_o=A0000005, if_pc_plus4_o=0x18; following cycle pc 0x18, A0000006; misalign_o stays 0.
- redirect_pc_i=0x1E → target forced to 0x1C, if_instr_o=A0000007, misalign_o=1 and stays 1 until rst.
- Run past word 15 (ADDR_W=4) → if_pc_o=0x40 with imem_addr_o wrapping to 0, if_instr_o=A0000000.
- Assert rst asynchronously mid-cycle during a stall → if_valid_o=0, if_instr_o=0x00000013, fetch_count_o=0 immediately; after release fetch restarts at pc 0.
